// File: rtl/iob_ram_2p_asym.sv
// Asymmetric-width 2-port RAM adapter mapping narrow/wide ports onto N external MINDATA_W banks.
// Optional macro IOB_RAM_2P_ASYM_RDATA_REG_EN adds an output register (read latency 1 -> 2).
module iob_ram_2p_asym #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 10,
  parameter int N        = 4,
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
  localparam int NB        = $clog2(N),
  localparam int MINADDR_W = ADDR_W - NB,
  localparam int W_ADDR_W  = (W_DATA_W < R_DATA_W) ? ADDR_W : MINADDR_W,
  localparam int R_ADDR_W  = (R_DATA_W < W_DATA_W) ? ADDR_W : MINADDR_W
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 w_en,
  input  logic [W_ADDR_W-1:0]  w_addr,
  input  logic [W_DATA_W-1:0]  w_data,
  input  logic                 r_en,
  input  logic [R_ADDR_W-1:0]  r_addr,
  output logic [R_DATA_W-1:0]  r_data,
  output logic [N-1:0]         ext_mem_w_en,
  output logic [MINADDR_W-1:0] ext_mem_w_addr,
  output logic [MAXDATA_W-1:0] ext_mem_w_data,
  output logic                 ext_mem_r_en,
  output logic [MINADDR_W-1:0] ext_mem_r_addr,
  input  logic [MAXDATA_W-1:0] ext_mem_r_data
);

  logic [R_DATA_W-1:0] r_data_raw;

  generate
    if (W_DATA_W < R_DATA_W) begin : g_wr_narrow
      logic [NB-1:0] w_sel;
      assign w_sel = w_addr[NB-1:0];
      always_comb begin
        ext_mem_w_en        = '0;
        ext_mem_w_en[w_sel] = w_en;
      end
      assign ext_mem_w_addr = w_addr[ADDR_W-1:NB];
      // Every bank sees the same narrow word; only the enabled lane stores it.
      assign ext_mem_w_data = {N{w_data}};
    end else begin : g_wr_wide
      assign ext_mem_w_en   = {N{w_en}};
      assign ext_mem_w_addr = w_addr;
      assign ext_mem_w_data = w_data;
    end
  endgenerate

  assign ext_mem_r_en = r_en;

  generate
    if (R_DATA_W < W_DATA_W) begin : g_rd_narrow
      logic [NB-1:0]        sel_q;
      logic [NB-1:0]        sel_d;
      logic [MINDATA_W-1:0] rd_lane [N];

      for (genvar k = 0; k < N; k++) begin : g_lane
        assign rd_lane[k] = ext_mem_r_data[k*MINDATA_W +: MINDATA_W];
      end

      // Lane select tracks the address that produced the bank output currently on the bus.
      assign sel_d = r_en ? r_addr[NB-1:0] : sel_q;

      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          sel_q <= '0;
        end else begin
          sel_q <= sel_d;
        end
      end

      assign ext_mem_r_addr = r_addr[ADDR_W-1:NB];
      assign r_data_raw     = rd_lane[sel_q];
    end else begin : g_rd_wide
      assign ext_mem_r_addr = r_addr;
      assign r_data_raw     = ext_mem_r_data;
    end
  endgenerate

`ifdef IOB_RAM_2P_ASYM_RDATA_REG_EN
  logic                r_vld_q;
  logic [R_DATA_W-1:0] r_data_q;
  logic [R_DATA_W-1:0] r_data_d;

  assign r_data_d = r_vld_q ? r_data_raw : r_data_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_vld_q  <= 1'b0;
      r_data_q <= '0;
    end else begin
      r_vld_q  <= r_en;
      r_data_q <= r_data_d;
    end
  end

  assign r_data = r_data_q;
`else
  assign r_data = r_data_raw;
`endif

endmodule

// File: tb/tb_iob_ram_2p_asym.sv
// Bench for iob_ram_2p_asym: three width configurations, each with a behavioural bank model.
module tb_iob_ram_2p_asym;

`ifdef IOB_RAM_2P_ASYM_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic arst;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: W=32, R=8 ----------------
  logic        a_w_en, a_r_en;
  logic [7:0]  a_w_addr;
  logic [31:0] a_w_data;
  logic [9:0]  a_r_addr;
  logic [7:0]  a_r_data;
  logic [3:0]  a_ext_w_en;
  logic [7:0]  a_ext_w_addr, a_ext_r_addr;
  logic [31:0] a_ext_w_data, a_ext_r_data;
  logic        a_ext_r_en;

  iob_ram_2p_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(10), .N(4)) u_a (
    .clk(clk), .arst(arst),
    .w_en(a_w_en), .w_addr(a_w_addr), .w_data(a_w_data),
    .r_en(a_r_en), .r_addr(a_r_addr), .r_data(a_r_data),
    .ext_mem_w_en(a_ext_w_en), .ext_mem_w_addr(a_ext_w_addr), .ext_mem_w_data(a_ext_w_data),
    .ext_mem_r_en(a_ext_r_en), .ext_mem_r_addr(a_ext_r_addr), .ext_mem_r_data(a_ext_r_data)
  );

  logic [31:0] mem_a [256];
  logic [31:0] a_bank_rd;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (a_ext_w_en[k]) mem_a[a_ext_w_addr][k*8 +: 8] <= a_ext_w_data[k*8 +: 8];
    if (a_ext_r_en) a_bank_rd <= mem_a[a_ext_r_addr];
  end
  assign a_ext_r_data = a_bank_rd;

  // ---------------- instance B: W=8, R=32 ----------------
  logic        b_w_en, b_r_en;
  logic [9:0]  b_w_addr;
  logic [7:0]  b_w_data;
  logic [7:0]  b_r_addr;
  logic [31:0] b_r_data;
  logic [3:0]  b_ext_w_en;
  logic [7:0]  b_ext_w_addr, b_ext_r_addr;
  logic [31:0] b_ext_w_data, b_ext_r_data;
  logic        b_ext_r_en;

  iob_ram_2p_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(10), .N(4)) u_b (
    .clk(clk), .arst(arst),
    .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data),
    .r_en(b_r_en), .r_addr(b_r_addr), .r_data(b_r_data),
    .ext_mem_w_en(b_ext_w_en), .ext_mem_w_addr(b_ext_w_addr), .ext_mem_w_data(b_ext_w_data),
    .ext_mem_r_en(b_ext_r_en), .ext_mem_r_addr(b_ext_r_addr), .ext_mem_r_data(b_ext_r_data)
  );

  logic [31:0] mem_b [256];
  logic [31:0] b_bank_rd;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (b_ext_w_en[k]) mem_b[b_ext_w_addr][k*8 +: 8] <= b_ext_w_data[k*8 +: 8];
    if (b_ext_r_en) b_bank_rd <= mem_b[b_ext_r_addr];
  end
  assign b_ext_r_data = b_bank_rd;

  // ---------------- instance C: W=R=16 ----------------
  logic        c_w_en, c_r_en;
  logic [3:0]  c_w_addr, c_r_addr;
  logic [15:0] c_w_data, c_r_data;
  logic [0:0]  c_ext_w_en;
  logic [3:0]  c_ext_w_addr, c_ext_r_addr;
  logic [15:0] c_ext_w_data, c_ext_r_data;
  logic        c_ext_r_en;

  iob_ram_2p_asym #(.W_DATA_W(16), .R_DATA_W(16), .ADDR_W(4), .N(1)) u_c (
    .clk(clk), .arst(arst),
    .w_en(c_w_en), .w_addr(c_w_addr), .w_data(c_w_data),
    .r_en(c_r_en), .r_addr(c_r_addr), .r_data(c_r_data),
    .ext_mem_w_en(c_ext_w_en), .ext_mem_w_addr(c_ext_w_addr), .ext_mem_w_data(c_ext_w_data),
    .ext_mem_r_en(c_ext_r_en), .ext_mem_r_addr(c_ext_r_addr), .ext_mem_r_data(c_ext_r_data)
  );

  logic [15:0] mem_c [16];
  logic [15:0] c_bank_rd;
  always @(posedge clk) begin
    if (c_ext_w_en[0]) mem_c[c_ext_w_addr] <= c_ext_w_data;
    if (c_ext_r_en) c_bank_rd <= mem_c[c_ext_r_addr];
  end
  assign c_ext_r_data = c_bank_rd;

  // ---------------- reference: flat byte-addressed memories ----------------
  logic [7:0] ref_a [1024];
  logic [7:0] ref_b [1024];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [7:0] wa, input logic [31:0] wd);
    a_w_en = 1'b1; a_w_addr = wa; a_w_data = wd;
    tick();
    a_w_en = 1'b0;
    for (int j = 0; j < 4; j++) ref_a[int'(wa)*4 + j] = wd[j*8 +: 8];
  endtask

  task automatic rd_a(input logic [9:0] ra, output logic [7:0] d);
    a_r_en = 1'b1; a_r_addr = ra;
    tick();
    a_r_en = 1'b0;
    repeat (LAT - 1) tick();
    d = a_r_data;
  endtask

  task automatic wr_b(input logic [9:0] wa, input logic [7:0] wd);
    b_w_en = 1'b1; b_w_addr = wa; b_w_data = wd;
    #1;
    check("b_rand_wen", b_ext_w_en, 64'(4'b0001 << (wa % 4)));
    check("b_rand_waddr", b_ext_w_addr, 64'(wa / 4));
    tick();
    b_w_en = 1'b0;
    ref_b[wa] = wd;
  endtask

  task automatic rd_b(input logic [7:0] ra, output logic [31:0] d);
    b_r_en = 1'b1; b_r_addr = ra;
    tick();
    b_r_en = 1'b0;
    repeat (LAT - 1) tick();
    d = b_r_data;
  endtask

  typedef struct {
    logic [9:0]  waddr;
    logic [7:0]  wdata;
    logic [3:0]  exp_wen;
    logic [7:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } wvec_t;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t       tbl [8];
    logic [7:0]  d8;
    logic [31:0] d32;
    logic [7:0]  exp8 [4];
    logic [31:0] wd;
    logic [9:0]  ra;
    int          idx;

    total = 0; bad = 0;
    arst = 1'b1;
    a_w_en = 0; a_w_addr = 0; a_w_data = 0; a_r_en = 0; a_r_addr = 0;
    b_w_en = 0; b_w_addr = 0; b_w_data = 0; b_r_en = 0; b_r_addr = 0;
    c_w_en = 0; c_w_addr = 0; c_w_data = 0; c_r_en = 0; c_r_addr = 0;

    tbl[0] = '{10'd0,    8'h0A, 4'b0001, 8'd0,   32'h0A0A0A0A};
    tbl[1] = '{10'd1,    8'h0B, 4'b0010, 8'd0,   32'h0B0B0B0B};
    tbl[2] = '{10'd2,    8'h0C, 4'b0100, 8'd0,   32'h0C0C0C0C};
    tbl[3] = '{10'd3,    8'h0D, 4'b1000, 8'd0,   32'h0D0D0D0D};
    tbl[4] = '{10'd1020, 8'hCC, 4'b0001, 8'd255, 32'hCCCCCCCC};
    tbl[5] = '{10'd1021, 8'hDD, 4'b0010, 8'd255, 32'hDDDDDDDD};
    tbl[6] = '{10'd1022, 8'hEE, 4'b0100, 8'd255, 32'hEEEEEEEE};
    tbl[7] = '{10'd1023, 8'hFF, 4'b1000, 8'd255, 32'hFFFFFFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
`ifdef IOB_RAM_2P_ASYM_RDATA_REG_EN
    check("rst_a_rdata", a_r_data, 64'h0);
    check("rst_b_rdata", b_r_data, 64'h0);
`else
    check("rst_a_rdata", a_r_data, 64'(a_bank_rd[7:0]));
    check("rst_b_rdata", b_r_data, 64'(b_bank_rd));
`endif
    check("rst_a_wen", a_ext_w_en, 64'h0);
    check("rst_a_ren", a_ext_r_en, 64'h0);
    check("rst_b_wen", b_ext_w_en, 64'h0);
    arst = 1'b0;
    tick();

    // Wide write / narrow read over the whole capacity
    for (int k = 0; k < 256; k++) wr_a(8'(k), 32'(k + 10));
    for (int b = 0; b < 1024; b++) begin
      rd_a(10'(b), d8);
      check("a_fill_byte", d8, 64'((((b / 4) + 10) >> (8 * (b % 4))) & 8'hFF));
    end
    check("a_byte1020", ref_a[1020], 64'h09);

    // Reset between edges after a read of byte 6
    rd_a(10'd6, d8);
    check("rst_mid_byte6", d8, 64'(ref_a[6]));
    #2 arst = 1'b1;
    #1;
`ifdef IOB_RAM_2P_ASYM_RDATA_REG_EN
    check("rst_mid_rdata", a_r_data, 64'h0);
`else
    check("rst_mid_rdata", a_r_data, 64'(ref_a[4]));
`endif
    #2 arst = 1'b0;
    tick();
    rd_a(10'd7, d8);
    check("rst_mid_byte7", d8, 64'(ref_a[7]));

    // Single wide write is one cycle on all four banks
    a_w_en = 1'b1; a_w_addr = 8'd3; a_w_data = 32'h11223344;
    #1;
    check("w3_wen", a_ext_w_en, 64'hF);
    check("w3_waddr", a_ext_w_addr, 64'd3);
    check("w3_wdata", a_ext_w_data, 64'h11223344);
    tick();
    a_w_en = 1'b0;
    for (int j = 0; j < 4; j++) ref_a[12 + j] = a_w_data[j*8 +: 8];
    #1;
    check("w3_wen_off", a_ext_w_en, 64'h0);

    // Back-to-back byte reads of word 3
    exp8[0] = 8'h44; exp8[1] = 8'h33; exp8[2] = 8'h22; exp8[3] = 8'h11;
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      if (i < 4) begin
        a_r_en = 1'b1; a_r_addr = 10'(12 + i);
      end else begin
        a_r_en = 1'b0;
      end
      #1;
      if (i < 4) check("w3_raddr", a_ext_r_addr, 64'd3);
      @(posedge clk); #1;
      idx = i - (LAT - 1);
      if (idx >= 0 && idx < 4) check("w3_rbyte", a_r_data, 64'(exp8[idx]));
    end
    a_r_en = 1'b0;

    // Narrow write table for instance B
    foreach (tbl[i]) begin
      b_w_en = 1'b1; b_w_addr = tbl[i].waddr; b_w_data = tbl[i].wdata;
      #1;
      check("b_tbl_wen", b_ext_w_en, 64'(tbl[i].exp_wen));
      check("b_tbl_waddr", b_ext_w_addr, 64'(tbl[i].exp_waddr));
      check("b_tbl_wdata", b_ext_w_data, 64'(tbl[i].exp_wdata));
      tick();
      ref_b[tbl[i].waddr] = tbl[i].wdata;
    end
    b_w_en = 1'b0;
    #1;
    check("b_wen_off", b_ext_w_en, 64'h0);
    rd_b(8'd0, d32);
    check("b_word0", d32, 64'h0D0C0B0A);
    rd_b(8'd255, d32);
    check("b_word255", d32, 64'hFFEEDDCC);

    // Equal widths
    c_w_en = 1'b1; c_w_addr = 4'd5; c_w_data = 16'hBEEF;
    #1;
    check("c_wen", c_ext_w_en, 64'h1);
    check("c_waddr", c_ext_w_addr, 64'd5);
    tick();
    c_w_en = 1'b0;
    c_r_en = 1'b1; c_r_addr = 4'd5;
    tick();
    c_r_en = 1'b0;
    repeat (LAT - 1) tick();
    check("c_rdata", c_r_data, 64'hBEEF);

    // Random traffic on A against the byte model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        wr_a(8'($urandom_range(0, 255)), wd);
      end else begin
        ra = 10'($urandom_range(0, 1023));
        rd_a(ra, d8);
        check("a_rand_read", d8, 64'(ref_a[ra]));
      end
    end

    // Random traffic on B: fill, then mixed byte writes and word reads
    for (int b = 0; b < 1024; b++) wr_b(10'(b), 8'($urandom));
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr_b(10'($urandom_range(0, 1023)), 8'($urandom));
      end else begin
        idx = $urandom_range(0, 255);
        rd_b(8'(idx), d32);
        check("b_rand_read", d32,
              64'({ref_b[idx*4+3], ref_b[idx*4+2], ref_b[idx*4+1], ref_b[idx*4]}));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
